// File: rtl/shift_sequencer_if.sv
// Request, status and reg_file control bundle between decode/control, shift_sequencer and reg_file.
// The master side issues requests and observes status; the slave side is the sequencer itself.
interface shift_sequencer_if #(
    parameter int IDX_W   = 5,
    parameter int SHAMT_W = 5
);
    logic               start;
    logic [SHAMT_W-1:0] shamt;
    logic               dir;
    logic               arith;
    logic [IDX_W-1:0]   rs1_index;
    logic [IDX_W-1:0]   rd_index;
    logic               stall;
    logic               busy;
    logic               done;
    logic [IDX_W-1:0]   rf_rs2_index;
    logic [IDX_W-1:0]   rf_rd_index;
    logic               rf_data2bus_en;
    logic               rf_exp_go_dn;
    logic               rf_shift_en;
    logic [1:0]         rf_shift_ctrl;
    logic               rf_move_en;
    logic               rf_write_en;

    modport master (
        output start, shamt, dir, arith, rs1_index, rd_index, stall,
        input  busy, done, rf_rs2_index, rf_rd_index, rf_data2bus_en,
               rf_exp_go_dn, rf_shift_en, rf_shift_ctrl, rf_move_en, rf_write_en
    );

    modport slave (
        input  start, shamt, dir, arith, rs1_index, rd_index, stall,
        output busy, done, rf_rs2_index, rf_rd_index, rf_data2bus_en,
               rf_exp_go_dn, rf_shift_en, rf_shift_ctrl, rf_move_en, rf_write_en
    );
endinterface

// File: rtl/shift_sequencer.sv
// Turns one shift request into shamt one-bit read-shift-write passes through reg_file's rs2 path.
// Handshake: start is sampled only in IDLE; busy covers the accept edge through DONE; done pulses once.
module shift_sequencer #(
    parameter int IDX_W   = 5,
    parameter int SHAMT_W = 5
) (
    input  logic                clk,
    input  logic                rst,
    shift_sequencer_if.slave    bus,
    output logic [1:0]          state_dbg
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_MOVE  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t             state, state_nx;
    logic [SHAMT_W-1:0] cnt, cnt_nx;
    logic               first, first_nx;
    logic [IDX_W-1:0]   rs1_q, rd_q;
    logic               dir_q, arith_q;
    logic               accept;

    assign accept    = (state == S_IDLE) && bus.start;
    assign state_dbg = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            cnt     <= '0;
            first   <= 1'b0;
            rs1_q   <= '0;
            rd_q    <= '0;
            dir_q   <= 1'b0;
            arith_q <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            first <= first_nx;
            if (accept) begin
                rs1_q   <= bus.rs1_index;
                rd_q    <= bus.rd_index;
                dir_q   <= bus.dir;
                arith_q <= bus.arith;
            end
        end
    end

    // Next state. x0 is never written, and a zero-amount copy onto itself is a no-op.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        first_nx = first;
        case (state)
            S_IDLE: begin
                if (bus.start) begin
                    cnt_nx   = bus.shamt;
                    first_nx = 1'b1;
                    if (bus.rd_index == '0)
                        state_nx = S_DONE;
                    else if ((bus.shamt == '0) && (bus.rs1_index == bus.rd_index))
                        state_nx = S_DONE;
                    else if (bus.shamt == '0)
                        state_nx = S_MOVE;
                    else
                        state_nx = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (!bus.stall) begin
                    cnt_nx   = cnt - SHAMT_W'(1);
                    first_nx = 1'b0;
                    if (cnt == SHAMT_W'(1))
                        state_nx = S_DONE;
                end
            end
            S_MOVE: begin
                if (!bus.stall)
                    state_nx = S_DONE;
            end
            S_DONE: begin
                state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    // Outputs decode only registered state plus stall; start never reaches rf_*.
    always_comb begin
        bus.busy           = (state != S_IDLE);
        bus.done           = (state == S_DONE);
        bus.rf_rs2_index   = '0;
        bus.rf_rd_index    = '0;
        bus.rf_data2bus_en = 1'b0;
        bus.rf_exp_go_dn   = 1'b0;
        bus.rf_shift_en    = 1'b0;
        bus.rf_shift_ctrl  = 2'b00;
        bus.rf_move_en     = 1'b0;
        bus.rf_write_en    = 1'b0;
        case (state)
            S_SHIFT: begin
                bus.rf_data2bus_en = 1'b1;
                bus.rf_exp_go_dn   = 1'b1;
                bus.rf_shift_en    = 1'b1;
                bus.rf_shift_ctrl  = {dir_q, dir_q & arith_q};
                bus.rf_write_en    = ~bus.stall;
                bus.rf_rd_index    = rd_q;
                bus.rf_rs2_index   = first ? rs1_q : rd_q;
            end
            S_MOVE: begin
                bus.rf_data2bus_en = 1'b1;
                bus.rf_exp_go_dn   = 1'b1;
                bus.rf_move_en     = 1'b1;
                bus.rf_shift_ctrl  = {dir_q, dir_q & arith_q};
                bus.rf_write_en    = ~bus.stall;
                bus.rf_rd_index    = rd_q;
                bus.rf_rs2_index   = rs1_q;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_shift_sequencer.sv
// Bench for shift_sequencer: a reg_file stand-in applies the one-bit writes, and a scoreboard
// checks each finished request against a whole-word shift of the source value.
module tb_shift_sequencer;
  localparam int IDX_W   = 5;
  localparam int SHAMT_W = 5;
  localparam int EXP_W   = IDX_W + 32 + 6;

  logic clk = 1'b0;
  logic rst;
  logic [1:0] state_dbg;
  always #5 clk = ~clk;

  shift_sequencer_if #(.IDX_W(IDX_W), .SHAMT_W(SHAMT_W)) bus ();

  shift_sequencer #(.IDX_W(IDX_W), .SHAMT_W(SHAMT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.slave),
    .state_dbg (state_dbg)
  );

  logic [31:0]      regs [32];
  logic [EXP_W-1:0] exp_q [$];
  int               total = 0;
  int               bad = 0;
  int               done_cnt = 0;
  int               writes_seen = 0;
  int               active_cyc = 0;
  int               stall_cyc = 0;
  int               age = 0;
  int unsigned      stall_pct = 0;
  logic             regs_init = 1'b0;
  logic             rst_d = 1'b0;
  logic             pre_we = 1'b0;
  logic [4:0]       pre_idx = '0;
  logic [31:0]      pre_val = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // reg_file stand-in: one write moves or shifts the rs2 word by one bit into rd
  task automatic env_write();
    logic [31:0] src, nv;
    src = regs[bus.rf_rs2_index];
    if (bus.rf_shift_en) begin
      if (!bus.rf_shift_ctrl[1]) nv = {src[30:0], 1'b0};
      else if (bus.rf_shift_ctrl[0]) nv = {src[31], src[31:1]};
      else nv = {1'b0, src[31:1]};
    end else begin
      nv = src;
    end
    regs[bus.rf_rd_index] = nv;
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    logic [EXP_W-1:0] e;
    logic [16:0] rf_bits;
    rf_bits = {bus.rf_data2bus_en, bus.rf_exp_go_dn, bus.rf_shift_en, bus.rf_shift_ctrl,
               bus.rf_move_en, bus.rf_write_en, bus.rf_rs2_index, bus.rf_rd_index};
    if (!regs_init) begin
      for (int i = 0; i < 32; i++) regs[i] = (i == 0) ? 32'h0 : $urandom;
      regs_init = 1'b1;
    end
    if (pre_we) regs[pre_idx] = pre_val;
    if (rst) begin
      if (bus.rf_write_en) env_write();
      exp_q.delete();
      writes_seen = 0; active_cyc = 0; stall_cyc = 0; age = 0;
    end else begin
      if (rst_d) begin
        check("rst_state", 64'(state_dbg), 64'd0);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_done", 64'(bus.done), 64'd0);
      end
      if (bus.rf_write_en) begin
        writes_seen++;
        check("write_during_stall", 64'(bus.stall), 64'd0);
        check("write_read_path", 64'({bus.rf_data2bus_en, bus.rf_exp_go_dn}), 64'd3);
        if (exp_q.size() != 0) check("write_rd_index", 64'(bus.rf_rd_index), 64'(exp_q[0][EXP_W-1 -: IDX_W]));
        env_write();
      end
      if (bus.rf_shift_en && !bus.rf_shift_ctrl[1]) check("left_arith", 64'(bus.rf_shift_ctrl[0]), 64'd0);
      check("busy", 64'(bus.busy), 64'(exp_q.size() != 0));
      if (!bus.busy || bus.done) check("rf_quiet", 64'(rf_bits), 64'd0);
      if (bus.busy && !bus.done) begin
        active_cyc++;
        if (bus.stall) stall_cyc++;
      end
      if (exp_q.size() != 0) age++;
      if (bus.done) begin
        if (exp_q.size() == 0) begin
          check("done_spurious", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("result", 64'(regs[e[EXP_W-1 -: IDX_W]]), 64'(e[37:6]));
          check("write_count", 64'(writes_seen), 64'(e[5:0]));
          check("unstalled_cycles", 64'(active_cyc - stall_cyc), 64'(e[5:0]));
        end
        writes_seen = 0; active_cyc = 0; stall_cyc = 0; age = 0;
        done_cnt++;
      end else if (age > 300) begin
        check("done_timeout", 64'd0, 64'd1);
        exp_q.delete();
        writes_seen = 0; active_cyc = 0; stall_cyc = 0; age = 0;
        done_cnt++;
      end
    end
    rst_d = rst;
  end

  task automatic preload(input logic [4:0] idx, input logic [31:0] val);
    pre_idx = idx; pre_val = val; pre_we = 1'b1;
    @(posedge clk); #1;
    pre_we = 1'b0;
  endtask

  function automatic logic [EXP_W-1:0] model(input logic [4:0] rs1, input logic [4:0] rd,
                                             input logic [4:0] sh, input logic dir, input logic arith);
    logic [31:0] s, v;
    int w;
    s = regs[rs1];
    if (rd == 0) begin v = 32'h0; w = 0; end
    else if (sh == 0) begin v = s; w = (rs1 == rd) ? 0 : 1; end
    else begin
      w = int'(sh);
      if (!dir) v = s << sh;
      else if (arith) v = $signed(s) >>> sh;
      else v = s >> sh;
    end
    return {rd, v, 6'(w)};
  endfunction

  task automatic drive_junk();
    bus.start = 1'($urandom_range(0, 1));
    bus.shamt = 5'($urandom); bus.dir = 1'($urandom); bus.arith = 1'($urandom);
    bus.rs1_index = 5'($urandom); bus.rd_index = 5'($urandom);
  endtask

  task automatic do_req(input logic [4:0] rs1, input logic [4:0] rd, input logic [4:0] sh,
                        input logic dir, input logic arith, input logic junk);
    logic [EXP_W-1:0] e;
    int d0, cyc;
    e = model(rs1, rd, sh, dir, arith);
    bus.start = 1'b1; bus.rs1_index = rs1; bus.rd_index = rd;
    bus.shamt = sh; bus.dir = dir; bus.arith = arith; bus.stall = 1'b0;
    @(posedge clk); #1;
    exp_q.push_back(e);
    d0 = done_cnt;
    cyc = 0;
    bus.start = 1'b0;
    while (done_cnt == d0 && cyc < 400) begin
      bus.stall = ($urandom_range(0, 99) < stall_pct);
      if (junk) drive_junk();
      @(posedge clk); #1;
      cyc++;
    end
    bus.start = 1'b0; bus.stall = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    bus.start = 1'b0; bus.shamt = '0; bus.dir = 1'b0; bus.arith = 1'b0;
    bus.rs1_index = '0; bus.rd_index = '0; bus.stall = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    preload(5'd5, 32'h0000_0001);
    do_req(5'd5, 5'd6, 5'd3, 1'b0, 1'b0, 1'b0);
    preload(5'd5, 32'h8000_0000);
    do_req(5'd5, 5'd6, 5'd31, 1'b1, 1'b1, 1'b0);
    do_req(5'd5, 5'd6, 5'd31, 1'b1, 1'b0, 1'b0);
    do_req(5'd5, 5'd6, 5'd31, 1'b0, 1'b1, 1'b0);
    preload(5'd5, 32'h0000_0001);
    stall_pct = 40;
    do_req(5'd5, 5'd6, 5'd3, 1'b0, 1'b0, 1'b0);
    stall_pct = 0;
    do_req(5'd5, 5'd0, 5'd4, 1'b0, 1'b0, 1'b0);
    preload(5'd7, 32'hDEAD_BEEF);
    do_req(5'd7, 5'd8, 5'd0, 1'b0, 1'b0, 1'b0);
    do_req(5'd9, 5'd9, 5'd0, 1'b1, 1'b1, 1'b0);
    do_req(5'd7, 5'd7, 5'd4, 1'b1, 1'b1, 1'b0);
    do_req(5'd7, 5'd10, 5'd5, 1'b1, 1'b0, 1'b1);

    // abort during the second of five shift iterations
    bus.start = 1'b1; bus.rs1_index = 5'd7; bus.rd_index = 5'd11;
    bus.shamt = 5'd5; bus.dir = 1'b0; bus.arith = 1'b0;
    @(posedge clk); #1;
    exp_q.push_back(model(5'd7, 5'd11, 5'd5, 1'b0, 1'b0));
    bus.start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    do_req(5'd7, 5'd11, 5'd5, 1'b0, 1'b0, 1'b0);

    stall_pct = 25;
    for (int n = 0; n < 60; n++) begin
      logic [4:0] rs1, rd, sh;
      rs1 = 5'($urandom);
      rd  = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      sh  = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom);
      if ($urandom_range(0, 7) == 0) rs1 = rd;
      do_req(rs1, rd, sh, 1'($urandom), 1'($urandom), 1'($urandom));
    end

    repeat (4) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
